// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the keypad scanner and its consumers: NOKEY code,
// scanner FSM encoding and matrix position to key code decoding.
package keypad_scanner_pkg;

  localparam logic [3:0] NOKEY = 4'hF;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2
  } scan_state_t;

  // Digit code for row/column; '*' and '#' (and unused column 3) give NOKEY.
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = NOKEY;
    if (col != 2'd3) begin
      case (row)
        2'd0: code = 4'd1 + {2'b00, col};
        2'd1: code = 4'd4 + {2'b00, col};
        2'd2: code = 4'd7 + {2'b00, col};
        default: code = (col == 2'd1) ? 4'd0 : NOKEY;
      endcase
    end
    return code;
  endfunction

  function automatic logic single_low(input logic [3:0] rows);
    return (rows == 4'b1110) || (rows == 4'b1101) ||
           (rows == 4'b1011) || (rows == 4'b0111);
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] rows);
    logic [1:0] idx;
    case (rows)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchroniser for the asynchronous keypad rows; resets to the
// idle (all released, all-ones) level so no phantom press follows reset.
module keypad_row_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= '1;
      dout <= '1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: drives one column at a time, debounces press and
// release, and presents a held digit code (or NOKEY) with a press strobe.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CNT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  row_n,
  output logic [2:0]  col_n,
  output logic [3:0]  key,
  output logic        key_pulse,
  output scan_state_t fsm_state
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_DONE   = DW'(DEBOUNCE_CNT);

  scan_state_t   state, state_next;
  logic [3:0]    rs;
  logic [1:0]    col_idx;
  logic [SW-1:0] slot_cnt;
  logic [DW-1:0] deb_cnt;
  logic [DW-1:0] rel_cnt;
  logic [3:0]    row_pat;
  logic [3:0]    code_lat;

  logic          sample;
  logic          hit;
  logic [3:0]    sample_code;
  logic          deb_match;
  logic          deb_done;
  logic          rel_done;
  logic          advance_col;

  keypad_row_sync #(.WIDTH(4)) u_row_sync (
    .clock (clock),
    .reset (reset),
    .din   (row_n),
    .dout  (rs)
  );

  assign sample      = (state == SCAN) && (slot_cnt == SLOT_LAST);
  assign sample_code = key_code(low_index(rs), col_idx);
  assign hit         = sample && single_low(rs) && (sample_code != NOKEY);
  assign deb_match   = (rs == row_pat);
  assign deb_done    = (deb_cnt == DB_DONE);
  assign rel_done    = (rel_cnt == DB_DONE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= SCAN;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    advance_col = 1'b0;
    case (state)
      SCAN: begin
        if (hit)         state_next  = DEBOUNCE;
        else if (sample) advance_col = 1'b1;
      end
      DEBOUNCE: begin
        if (deb_done) begin
          state_next = PRESSED;
        end else if (!deb_match) begin
          state_next  = SCAN;
          advance_col = 1'b1;
        end
      end
      PRESSED: begin
        if (rel_done) begin
          state_next  = SCAN;
          advance_col = 1'b1;
        end
      end
      default: state_next = SCAN;
    endcase
  end

  always_comb begin
    case (col_idx)
      2'd1:    col_n = 3'b101;
      2'd2:    col_n = 3'b011;
      default: col_n = 3'b110;
    endcase
    fsm_state = state;
  end

  // Counters are cleared whenever their state is left, so none can wrap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_idx   <= 2'd0;
      slot_cnt  <= '0;
      deb_cnt   <= '0;
      rel_cnt   <= '0;
      row_pat   <= 4'hF;
      code_lat  <= NOKEY;
      key       <= NOKEY;
      key_pulse <= 1'b0;
    end else begin
      if (advance_col) col_idx <= (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;

      if (state == SCAN && !sample) slot_cnt <= slot_cnt + 1'b1;
      else                          slot_cnt <= '0;

      if (state == DEBOUNCE && state_next == DEBOUNCE) deb_cnt <= deb_cnt + 1'b1;
      else                                             deb_cnt <= '0;

      if (state == PRESSED && !rel_done && rs == 4'hF) rel_cnt <= rel_cnt + 1'b1;
      else                                             rel_cnt <= '0;

      if (hit) begin
        row_pat  <= rs;
        code_lat <= sample_code;
      end

      if (state == DEBOUNCE && deb_done)     key <= code_lat;
      else if (state == PRESSED && rel_done) key <= NOKEY;

      key_pulse <= (state == DEBOUNCE) && deb_done;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x3 matrix keypad model.
module tb_keypad_scanner;
  import keypad_scanner_pkg::*;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  row_n;
  logic [2:0]  col_n;
  logic [3:0]  key;
  logic        key_pulse;
  scan_state_t fsm_state;

  logic [11:0] pressed;   // bit r*3+c set while that key is held
  int n_checks, n_pass, n_fail;
  int pulses, bad_pulses, col_moves, first_hit, col_bad;
  logic [2:0] last_col;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT)) dut (
    .clock     (clock),
    .reset     (reset),
    .row_n     (row_n),
    .col_n     (col_n),
    .key       (key),
    .key_pulse (key_pulse),
    .fsm_state (fsm_state)
  );

  always #5 clock = ~clock;

  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r*3+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    pulses = 0; bad_pulses = 0; col_moves = 0; col_bad = 0; first_hit = -1;
    last_col = col_n;
  endtask

  // Advance n cycles, sampling 1 time unit after each rising edge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      if (key_pulse) pulses++;
      if (key_pulse && key == NOKEY) bad_pulses++;
      if (col_n != last_col) col_moves++;
      last_col = col_n;
    end
  endtask

  task automatic wait_key(input logic [3:0] code, input int limit);
    for (int i = 0; i < limit && key != code; i++) run(1);
  endtask

  initial begin
    n_checks = 0; n_pass = 0; n_fail = 0;
    pressed = '0;
    reset = 1'b0;
    clear_stats();

    // Reset values and idle column rotation
    run(3);
    check("rst_col", 8'(col_n), 8'(3'b110));
    check("rst_key", 8'(key), 8'hF);
    check("rst_pulse", 8'(key_pulse), 8'd0);
    check("rst_state", 8'(fsm_state), 8'(SCAN));
    reset = 1'b1;
    run(3);
    check("scan_col0_hold", 8'(col_n), 8'(3'b110));
    run(1);
    check("scan_col1", 8'(col_n), 8'(3'b101));
    run(4);
    check("scan_col2", 8'(col_n), 8'(3'b011));
    run(4);
    check("scan_wrap_col0", 8'(col_n), 8'(3'b110));

    // Key '5' held 40 cycles
    clear_stats();
    pressed[4] = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      run(1);
      if (key == 4'd5 && first_hit < 0) first_hit = i;
      if (key == 4'd5 && col_n != 3'b101) col_bad++;
    end
    check("press5_latency_ok", 8'(first_hit >= 1 && first_hit <= 18), 8'd1);
    check("press5_key", 8'(key), 8'd5);
    check("press5_pulse_count", 8'(pulses), 8'd1);
    check("press5_col_frozen", 8'(col_bad), 8'd0);
    check("press5_state", 8'(fsm_state), 8'(PRESSED));

    // Release of '5': NOKEY exactly 6 cycles later, scan resumes at column 2
    pressed[4] = 1'b0;
    run(5);
    check("release5_still_held", 8'(key), 8'd5);
    run(1);
    check("release5_key", 8'(key), 8'hF);
    check("release5_col", 8'(col_n), 8'(3'b011));
    check("release5_state", 8'(fsm_state), 8'(SCAN));

    // Bounce on '1' during column 0 slot
    for (int i = 0; i < 16 && col_n != 3'b110; i++) run(1);
    check("bounce_col0_reached", 8'(col_n), 8'(3'b110));
    clear_stats();
    pressed[0] = 1'b1; run(2);
    pressed[0] = 1'b0; run(1);
    pressed[0] = 1'b1; run(2);
    pressed[0] = 1'b0; run(20);
    check("bounce_no_pulse", 8'(pulses), 8'd0);
    check("bounce_key", 8'(key), 8'hF);

    // Stable '1' after the bounce
    clear_stats();
    pressed[0] = 1'b1;
    wait_key(4'd1, 30);
    check("press1_key", 8'(key), 8'd1);
    check("press1_pulse_count", 8'(pulses), 8'd1);
    pressed[0] = 1'b0;
    run(8);
    check("release1_key", 8'(key), 8'hF);

    // '*' is not a digit
    clear_stats();
    pressed[9] = 1'b1;
    run(30);
    pressed[9] = 1'b0;
    check("star_key", 8'(key), 8'hF);
    check("star_no_pulse", 8'(pulses), 8'd0);
    check("star_col_rotates", 8'(col_moves >= 5), 8'd1);

    // Two rows low in column 1 ('2' and '8') are ignored
    clear_stats();
    pressed[1] = 1'b1;
    pressed[7] = 1'b1;
    run(30);
    pressed[1] = 1'b0;
    pressed[7] = 1'b0;
    check("multi_key", 8'(key), 8'hF);
    check("multi_no_pulse", 8'(pulses), 8'd0);
    check("multi_col_rotates", 8'(col_moves >= 5), 8'd1);
    check("no_pulse_on_nokey", 8'(bad_pulses), 8'd0);
    run(4);

    // Reset while '8' held
    clear_stats();
    pressed[7] = 1'b1;
    wait_key(4'd8, 30);
    check("press8_key", 8'(key), 8'd8);
    reset = 1'b0;
    #1;
    check("async_rst_key", 8'(key), 8'hF);
    check("async_rst_col", 8'(col_n), 8'(3'b110));
    check("async_rst_pulse", 8'(key_pulse), 8'd0);
    check("async_rst_state", 8'(fsm_state), 8'(SCAN));
    run(2);
    reset = 1'b1;
    clear_stats();
    run(3);
    check("post_rst_no_early_key", 8'(key), 8'hF);
    wait_key(4'd8, 30);
    run(5);
    check("repress8_key", 8'(key), 8'd8);
    check("repress8_pulse_count", 8'(pulses), 8'd1);
    pressed[7] = 1'b0;
    run(8);
    check("release8_key", 8'(key), 8'hF);
    check("final_no_pulse_on_nokey", 8'(bad_pulses), 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
